// File: rtl/fsm_pkg.sv
// fsm_pkg: state encodings shared by the run/done sequencer and the worker
// FSMs it drives. Keeping a single encoding lets waveforms and debug
// registers from either side be read with the same decode.
package fsm_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_DONE  = 2'b11
    } fsm_state_t;

endpackage

// File: rtl/fsm_run_ctrl_if.sv
// fsm_run_ctrl_if: request/status bundle between the control layer and the
// run sequencer, plus the run/done pair toward the worker.
//   i_start, i_num_loop : start request and iteration count
//   i_done              : worker done pulse
//   o_run               : worker run pulse
//   o_idle, o_running   : sequencer status
//   o_done, o_timeout   : completion pulse and abort flag
//   o_loop_cnt          : completed iterations
// Modports: master = control layer / worker side, slave = sequencer.
interface fsm_run_ctrl_if #(
    parameter int CNT_WIDTH = 8
);

    logic                 i_start;
    logic [CNT_WIDTH-1:0] i_num_loop;
    logic                 i_done;
    logic                 o_run;
    logic                 o_idle;
    logic                 o_running;
    logic                 o_done;
    logic                 o_timeout;
    logic [CNT_WIDTH-1:0] o_loop_cnt;

    modport master (
        output i_start, i_num_loop, i_done,
        input  o_run, o_idle, o_running, o_done, o_timeout, o_loop_cnt
    );

    modport slave (
        input  i_start, i_num_loop, i_done,
        output o_run, o_idle, o_running, o_done, o_timeout, o_loop_cnt
    );

endinterface

// File: rtl/fsm_watchdog.sv
// fsm_watchdog: per-iteration wait counter for the run sequencer.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : force count to zero (issued once per iteration)
//   enable       : count this cycle
//   terminal     : count has reached TIMEOUT-1
// The count saturates at the terminal value so a stalled enable can never
// wrap around and hide an expired wait.
module fsm_watchdog #(
    parameter int TIMEOUT  = 16,
    parameter int TO_WIDTH = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [TO_WIDTH-1:0] wd_cnt;

    assign terminal = (wd_cnt == TO_WIDTH'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (clear) begin
            wd_cnt <= '0;
        end else if (enable && !terminal) begin
            wd_cnt <= wd_cnt + TO_WIDTH'(1);
        end
    end

endmodule

// File: rtl/fsm_run_ctrl.sv
// fsm_run_ctrl: initiator-side sequencer for a run/done worker. A start
// request launches a programmed number of run/done iterations; each wait
// for done is bounded by a watchdog, and the sequence ends with a one-cycle
// completion pulse (with o_timeout if it aborted).
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : fsm_run_ctrl_if slave modport (request, status, worker)
module fsm_run_ctrl
    import fsm_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int TIMEOUT   = 16,
    parameter int TO_WIDTH  = $clog2(TIMEOUT)
) (
    input  logic               clk,
    input  logic               reset_n,
    fsm_run_ctrl_if.slave      bus
);

    fsm_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 to_q, to_d;
    logic                 wd_clear;
    logic                 wd_en;
    logic                 wd_term;

    fsm_watchdog #(
        .TIMEOUT  (TIMEOUT),
        .TO_WIDTH (TO_WIDTH)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (wd_clear),
        .enable   (wd_en),
        .terminal (wd_term)
    );

    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    // The iteration target is only read after it has been latched on an
    // accepted start, so it carries no reset.
    always_ff @(posedge clk) begin
        num_q <= num_d;
    end

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        cnt_d    = cnt_q;
        to_d     = to_q;
        wd_clear = 1'b0;
        wd_en    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    cnt_d = '0;
                    to_d  = 1'b0;
                    if (bus.i_num_loop != '0) begin
                        num_d   = bus.i_num_loop;
                        state_d = S_ISSUE;
                    end else begin
                        // Zero iterations: complete immediately, no run.
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                wd_clear = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                wd_en = 1'b1;
                // Done is checked first so a done arriving on the terminal
                // watchdog cycle still counts as a completed iteration.
                if (bus.i_done) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == num_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if (wd_term) begin
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.o_run      = (state_q == S_ISSUE);
    assign bus.o_idle     = (state_q == S_IDLE);
    assign bus.o_running  = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign bus.o_done     = (state_q == S_DONE);
    assign bus.o_timeout  = to_q;
    assign bus.o_loop_cnt = cnt_q;

endmodule

// File: tb/tb_fsm_run_ctrl.sv
// tb_fsm_run_ctrl: drives fsm_run_ctrl with directed and randomized run
// sequences, playing the worker role. A timeline model derives, for each
// sequence, the cycle of every run pulse, every WAIT cycle and the final
// completion from the iteration count and per-iteration worker delays, and
// every output is compared against it cycle by cycle.
module tb_fsm_run_ctrl;

    localparam int CNT_WIDTH = 8;
    localparam int TIMEOUT   = 16;
    localparam int MAXC      = 1024;

    logic clk;
    logic reset_n;

    fsm_run_ctrl_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

    fsm_run_ctrl #(
        .CNT_WIDTH (CNT_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    int prev_cnt;
    int prev_to;

    // Worker delay per iteration: d in 1..TIMEOUT means done arrives in the
    // d-th WAIT cycle after the run pulse; 0 means the worker never answers.
    int dly_q[$];

    bit e_run  [MAXC];
    bit e_wait [MAXC];
    bit d_in   [MAXC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_dly(input int n, input int d);
        dly_q.delete();
        for (int i = 0; i < n; i++) dly_q.push_back(d);
    endtask

    // Runs one sequence starting at the next negedge (DUT must be idle).
    // Offset 0 is the cycle i_start is presented. If abort_off >= 0, reset
    // is asserted in that cycle and the task returns.
    task automatic run_seq(input int num, input bit hold, input int abort_off);
        int  done_off;
        int  t;
        int  cnt;
        bit  to;
        bit  stop;
        for (int i = 0; i < MAXC; i++) begin
            e_run[i]  = 1'b0;
            e_wait[i] = 1'b0;
            d_in[i]   = 1'b0;
        end
        done_off = 1;
        to       = 1'b0;
        stop     = 1'b0;
        t        = 1;
        for (int k = 0; k < num && !stop; k++) begin
            e_run[t] = 1'b1;
            if (dly_q[k] > 0) begin
                for (int j = 1; j <= dly_q[k]; j++) e_wait[t + j] = 1'b1;
                d_in[t + dly_q[k]] = 1'b1;
                if (k == num - 1) done_off = t + dly_q[k] + 1;
                else              t        = t + dly_q[k] + 1;
            end else begin
                for (int j = 1; j <= TIMEOUT; j++) e_wait[t + j] = 1'b1;
                done_off = t + TIMEOUT + 1;
                to       = 1'b1;
                stop     = 1'b1;
            end
        end

        cnt = 0;
        for (int off = 0; off <= done_off; off++) begin
            @(negedge clk);
            chk($sformatf("run@%0d", off),     bus.o_run,     e_run[off]);
            chk($sformatf("done@%0d", off),    bus.o_done,    off == done_off);
            chk($sformatf("running@%0d", off), bus.o_running, off >= 1 && off < done_off);
            chk($sformatf("idle@%0d", off),    bus.o_idle,    off == 0);
            if (off == 0) begin
                chk("cnt_hold", bus.o_loop_cnt, prev_cnt);
                chk("to_hold",  bus.o_timeout,  prev_to);
            end else begin
                chk($sformatf("cnt@%0d", off), bus.o_loop_cnt, cnt);
                chk($sformatf("to@%0d", off),  bus.o_timeout,  (off == done_off) ? to : 1'b0);
            end
            if (d_in[off]) cnt++;

            bus.i_start    = (off == 0) || hold || ($urandom_range(0, 3) == 0);
            bus.i_num_loop = (off == 0) ? CNT_WIDTH'(num) : CNT_WIDTH'($urandom_range(0, 255));
            bus.i_done     = d_in[off] || (!e_wait[off] && ($urandom_range(0, 2) == 0));
            if (off == abort_off) begin
                reset_n = 1'b0;
                return;
            end
        end
        prev_cnt = cnt;
        prev_to  = to;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        prev_cnt       = 0;
        prev_to        = 0;
        reset_n        = 1'b0;
        bus.i_start    = 1'b1;
        bus.i_num_loop = 8'd3;
        bus.i_done     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_idle",    bus.o_idle,     1);
        chk("rst_run",     bus.o_run,      0);
        chk("rst_done",    bus.o_done,     0);
        chk("rst_running", bus.o_running,  0);
        chk("rst_to",      bus.o_timeout,  0);
        chk("rst_cnt",     bus.o_loop_cnt, 0);
        reset_n     = 1'b1;
        bus.i_start = 1'b0;
        bus.i_done  = 1'b0;

        // Standard 3-state worker: done two cycles after run.
        set_dly(3, 2);
        run_seq(3, 1'b0, -1);
        // Zero iterations.
        run_seq(0, 1'b0, -1);
        // Worker never responds.
        set_dly(1, 0);
        run_seq(1, 1'b0, -1);
        // Done in the final allowed WAIT cycle.
        set_dly(2, TIMEOUT);
        run_seq(2, 1'b0, -1);
        // Zero-wait worker.
        set_dly(4, 1);
        run_seq(4, 1'b0, -1);
        // Timeout on the second iteration.
        dly_q.delete();
        dly_q.push_back(3);
        dly_q.push_back(0);
        run_seq(2, 1'b0, -1);
        // Start held high: back-to-back sequences.
        set_dly(1, 2);
        for (int i = 0; i < 4; i++) run_seq(1, 1'b1, -1);

        // Reset in the second iteration's wait of a num=5 sequence.
        set_dly(5, 4);
        run_seq(5, 1'b0, 8);
        @(negedge clk);
        chk("arst_idle",    bus.o_idle,     1);
        chk("arst_run",     bus.o_run,      0);
        chk("arst_done",    bus.o_done,     0);
        chk("arst_running", bus.o_running,  0);
        chk("arst_cnt",     bus.o_loop_cnt, 0);
        chk("arst_to",      bus.o_timeout,  0);
        reset_n     = 1'b1;
        bus.i_start = 1'b0;
        bus.i_done  = 1'b0;
        @(negedge clk);
        bus.i_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.i_done = 1'b0;
            chk($sformatf("late_done_idle%0d", i), bus.o_idle,     1);
            chk($sformatf("late_done_cnt%0d", i),  bus.o_loop_cnt, 0);
            chk($sformatf("late_done_done%0d", i), bus.o_done,     0);
        end
        prev_cnt = 0;
        prev_to  = 0;

        // Randomized sequences.
        for (int s = 0; s < 25; s++) begin
            int n;
            n = $urandom_range(0, 5);
            dly_q.delete();
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 7) == 0) dly_q.push_back(0);
                else                           dly_q.push_back($urandom_range(1, TIMEOUT));
            end
            run_seq(n, $urandom_range(0, 3) == 0, -1);
        end

        // Largest count, zero-wait worker.
        set_dly(255, 1);
        run_seq(255, 1'b0, -1);

        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_done  = 1'b0;
        chk("end_idle", bus.o_idle,     1);
        chk("end_cnt",  bus.o_loop_cnt, prev_cnt);
        chk("end_to",   bus.o_timeout,  prev_to);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
